// File: rtl/hazard_stall_ctrl.sv
// Hazard / stall controller for the 5-stage core.
// Covers what forwarding cannot. A load-use hazard stalls IF/ID for one cycle.
// A taken branch flushes the wrong-path fetches. A busy data memory freezes the
// whole pipe. Saturating counters record stall cycles and flush events.
module hazard_stall_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int MEM_TIMEOUT  = 64,
  parameter int STAT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic [4:0]        ex_rd,
  input  logic              ex_mem_read,
  input  logic              ex_reg_write,
  input  logic              ex_branch_taken,
  input  logic              mem_busy,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              if_id_flush,
  output logic              id_ex_bubble,
  output logic              pipe_freeze,
  output logic              mem_timeout,
  output logic [STAT_W-1:0] stall_cnt,
  output logic [STAT_W-1:0] flush_cnt
);

  localparam int FL_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;
  localparam int WT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WT_W-1:0] WAIT_MAX   = WT_W'(MEM_TIMEOUT);
  localparam logic [FL_W-1:0] FLUSH_INIT = FL_W'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    FLUSH   = 2'd1,
    MEMWAIT = 2'd2
  } state_t;

  state_t            state, state_nxt;
  state_t            saved_state, saved_nxt;
  state_t            eff_state;
  logic [FL_W-1:0]   flush_left, flush_left_nxt;
  logic [WT_W-1:0]   wait_cnt, wait_nxt;
  logic              timeout_set;
  logic              stall_inc;
  logic              flush_inc;
  logic              load_use;

  // Load in EX whose destination is read by the instruction in ID; x0 is never a hazard.
  assign load_use = ex_mem_read & ex_reg_write & (ex_rd != 5'd0) &
                    ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                     (id_uses_rs2 & (id_rs2 == ex_rd)));

  // The cycle mem_busy drops, the saved state resumes straight away.
  // No dead cycle is spent in MEMWAIT.
  assign eff_state = (state == MEMWAIT) ? saved_state : state;

  // Next-state and same-cycle control outputs, highest priority first.
  always_comb begin
    // NOTE: every output of this block gets a default first.
    // Otherwise a path that skips the assignment infers a latch.
    pc_write       = 1'b1;
    if_id_write    = 1'b1;
    if_id_flush    = 1'b0;
    id_ex_bubble   = 1'b0;
    pipe_freeze    = 1'b0;
    state_nxt      = state;
    saved_nxt      = saved_state;
    flush_left_nxt = flush_left;
    wait_nxt       = '0;
    timeout_set    = 1'b0;
    stall_inc      = 1'b0;
    flush_inc      = 1'b0;

    if (mem_busy) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      pipe_freeze = 1'b1;
      state_nxt   = MEMWAIT;
      // Record the state to resume. While already waiting, keep the original.
      // flush_left is simply held during the freeze.
      saved_nxt   = eff_state;
      wait_nxt    = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + 1'b1;
      timeout_set = (wait_nxt == WAIT_MAX);
    end else begin
      state_nxt = eff_state;
      case (eff_state)
        RUN: begin
          if (ex_branch_taken) begin
            // Branch wins over load-use: ID holds a wrong-path instruction anyway.
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            flush_inc    = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_nxt      = FLUSH;
              flush_left_nxt = FLUSH_INIT;
            end
          end else if (load_use) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            stall_inc    = 1'b1;
          end
        end
        FLUSH: begin
          // EX holds a bubble here, so branch and load-use inputs are ignored.
          if_id_flush = 1'b1;
          if (flush_left <= FL_W'(1)) begin
            flush_left_nxt = '0;
            state_nxt      = RUN;
          end else begin
            flush_left_nxt = flush_left - 1'b1;
          end
        end
        default: state_nxt = RUN;
      endcase
    end

    // While reset is held the pipe runs free with no flush, bubble or freeze.
    if (reset) begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      pipe_freeze  = 1'b0;
    end
  end

  // State, flush/wait counters and the sticky timeout flag.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments only.
    // Every register then updates from the same pre-edge values.
    if (reset) begin
      state       <= RUN;
      saved_state <= RUN;
      flush_left  <= '0;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      saved_state <= saved_nxt;
      flush_left  <= flush_left_nxt;
      wait_cnt    <= wait_nxt;
      if (timeout_set) mem_timeout <= 1'b1;
    end
  end

  // Saturating statistics counters; nothing is counted during a freeze.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (flush_inc && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule
